branch_predictor_btb: RTL and testbench

//  Direct-mapped branch target buffer with 2-bit saturating counters, feeding next-PC prediction to fetch.

---
 rtl/branch_predictor_btb.sv | 109 ++++++++++
 tb/tb_branch_predictor_btb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit saturating direction counters, combinational
// next-PC lookup for fetch, MEM-stage update, mispredict/redirect and perf counters.
module branch_predictor_btb #(
  parameter int N       = 64,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 12,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     pc_F,
  output logic             predTaken_F,
  output logic [N-1:0]     predTarget_F,
  input  logic             flush_all,
  input  logic             upd_valid,
  input  logic [N-1:0]     upd_pc,
  input  logic             upd_taken,
  input  logic [N-1:0]     upd_target,
  input  logic             upd_predTaken,
  input  logic [N-1:0]     upd_predTarget,
  output logic             mispredict_M,
  output logic [N-1:0]     redirect_M,
  output logic [CNT_W-1:0] branchCnt,
  output logic [CNT_W-1:0] mispredCnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [N-1:0] PC_STEP = N'(4);

  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'd1;
    else       return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [N-1:0]     target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [CNT_W-1:0] branchCnt_q, branchCnt_d;
  logic [CNT_W-1:0] mispredCnt_q, mispredCnt_d;

  logic [IDX_W-1:0] idx_f, idx_u;
  logic [TAG_W-1:0] tag_f, tag_u;
  logic             hit_f, hit_u;
  logic             wr_en_d;
  logic [1:0]       ctr_d;
  logic [N-1:0]     target_d;

  // Fetch-side lookup reads the current (pre-update) contents.
  always_comb begin
    idx_f        = pc_F[IDX_W+1:2];
    tag_f        = pc_F[IDX_W+2 +: TAG_W];
    hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    predTaken_F  = reset && hit_f && ctr_q[idx_f][1];
    predTarget_F = predTaken_F ? target_q[idx_f] : pc_F + PC_STEP;
  end

  always_comb begin
    mispredict_M = upd_valid &&
                   ((upd_taken != upd_predTaken) ||
                    (upd_taken && (upd_predTarget != upd_target)));
    redirect_M   = (upd_valid && upd_taken) ? upd_target : upd_pc + PC_STEP;
  end

  // Resolved-branch write port; a flush suppresses any entry write that cycle.
  always_comb begin
    idx_u        = upd_pc[IDX_W+1:2];
    tag_u        = upd_pc[IDX_W+2 +: TAG_W];
    hit_u        = valid_q[idx_u] && (tag_q[idx_u] == tag_u);
    wr_en_d      = upd_valid && !flush_all && (hit_u || upd_taken);
    ctr_d        = hit_u ? ctr_step(ctr_q[idx_u], upd_taken) : 2'b10;
    target_d     = upd_taken ? upd_target : target_q[idx_u];
    branchCnt_d  = sat_inc(branchCnt_q, upd_valid);
    mispredCnt_d = sat_inc(mispredCnt_q, mispredict_M);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b00;
      end
      branchCnt_q  <= '0;
      mispredCnt_q <= '0;
    end else begin
      if (flush_all) begin
        for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      end
      if (wr_en_d) begin
        valid_q[idx_u]  <= 1'b1;
        tag_q[idx_u]    <= tag_u;
        target_q[idx_u] <= target_d;
        ctr_q[idx_u]    <= ctr_d;
      end
      branchCnt_q  <= branchCnt_d;
      mispredCnt_q <= mispredCnt_d;
    end
  end

  assign branchCnt  = branchCnt_q;
  assign mispredCnt = mispredCnt_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: directed vector table, randomized traffic
// against an entry-level reference model, async reset and counter saturation.
module tb_branch_predictor_btb;

  localparam int N       = 64;
  localparam int ENTRIES = 16;
  localparam int TAG_W   = 12;
  localparam int IDX_W   = 4;
  localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAX4  = 15;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [63:0] pc_F;
  logic        flush_all, upd_valid, upd_taken, upd_predTaken;
  logic [63:0] upd_pc, upd_target, upd_predTarget;

  logic        predTaken_F, mispredict_M;
  logic [63:0] predTarget_F, redirect_M;
  logic [31:0] branchCnt, mispredCnt;

  logic        s_predTaken, s_mispredict;
  logic [63:0] s_predTarget, s_redirect;
  logic [3:0]  s_branchCnt, s_mispredCnt;

  branch_predictor_btb #(.N(N), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .pc_F(pc_F), .predTaken_F(predTaken_F),
    .predTarget_F(predTarget_F), .flush_all(flush_all), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_predTaken(upd_predTaken), .upd_predTarget(upd_predTarget),
    .mispredict_M(mispredict_M), .redirect_M(redirect_M),
    .branchCnt(branchCnt), .mispredCnt(mispredCnt));

  branch_predictor_btb #(.N(N), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .pc_F(pc_F), .predTaken_F(s_predTaken),
    .predTarget_F(s_predTarget), .flush_all(flush_all), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_predTaken(upd_predTaken), .upd_predTarget(upd_predTarget),
    .mispredict_M(s_mispredict), .redirect_M(s_redirect),
    .branchCnt(s_branchCnt), .mispredCnt(s_mispredCnt));

  int errors = 0;
  int checks = 0;

  // Reference model: one record per BTB slot plus plain integer counters.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [63:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  longint      m_bc, m_mc, m_bc4, m_mc4;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int m_idx(input logic [63:0] pc);
    return int'((pc >> 2) % 64'(ENTRIES));
  endfunction

  function automatic int unsigned m_tagof(input logic [63:0] pc);
    return int'((pc >> (IDX_W + 2)) % 64'(1 << TAG_W));
  endfunction

  function automatic bit m_hit(input logic [63:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
  endfunction

  function automatic bit m_pred_taken(input logic [63:0] pc);
    return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [63:0] m_pred_target(input logic [63:0] pc);
    return m_pred_taken(pc) ? m_tgt[m_idx(pc)] : pc + 64'd4;
  endfunction

  function automatic bit m_mispredict();
    return upd_valid && ((upd_taken != upd_predTaken) ||
                         (upd_taken && (upd_predTarget != upd_target)));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 64'd0; m_ctr[i] = 0;
    end
    m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
  endtask

  task automatic m_update();
    int i;
    bit mp;
    mp = m_mispredict();
    if (upd_valid) begin
      if (m_bc < MAX32) m_bc++;
      if (m_bc4 < MAX4) m_bc4++;
    end
    if (mp) begin
      if (m_mc < MAX32) m_mc++;
      if (m_mc4 < MAX4) m_mc4++;
    end
    i = m_idx(upd_pc);
    if (flush_all) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
    end else if (upd_valid) begin
      if (m_hit(upd_pc)) begin
        if (upd_taken) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (upd_taken) begin
        m_valid[i] = 1; m_tag[i] = m_tagof(upd_pc); m_tgt[i] = upd_target; m_ctr[i] = 2;
      end
    end
  endtask

  task automatic check_all(input string name);
    logic [63:0] rd;
    rd = (upd_valid && upd_taken) ? upd_target : upd_pc + 64'd4;
    chk({name, ".predTaken"},  64'(predTaken_F),  64'(m_pred_taken(pc_F)));
    chk({name, ".predTarget"}, predTarget_F,      m_pred_target(pc_F));
    chk({name, ".mispredict"}, 64'(mispredict_M), 64'(m_mispredict()));
    chk({name, ".redirect"},   redirect_M,        rd);
    chk({name, ".branchCnt"},  64'(branchCnt),    64'(m_bc));
    chk({name, ".mispredCnt"}, 64'(mispredCnt),   64'(m_mc));
    chk({name, ".s_predTaken"},  64'(s_predTaken),  64'(m_pred_taken(pc_F)));
    chk({name, ".s_predTarget"}, s_predTarget,      m_pred_target(pc_F));
    chk({name, ".s_mispredict"}, 64'(s_mispredict), 64'(m_mispredict()));
    chk({name, ".s_redirect"},   s_redirect,        rd);
    chk({name, ".s_branchCnt"},  64'(s_branchCnt),  64'(m_bc4));
    chk({name, ".s_mispredCnt"}, 64'(s_mispredCnt), 64'(m_mc4));
  endtask

  task automatic step(input string name);
    @(negedge clk);
    check_all(name);
    @(posedge clk);
    #1;
    m_update();
  endtask

  task automatic idle_inputs();
    flush_all = 1'b0; upd_valid = 1'b0; upd_pc = 64'd0; upd_taken = 1'b0;
    upd_target = 64'd0; upd_predTaken = 1'b0; upd_predTarget = 64'd0;
  endtask

  function automatic logic [63:0] rand_pc();
    logic [63:0] p;
    p = {$urandom, $urandom};
    p[17:6] = 12'($urandom_range(1, 3));
    return p;
  endfunction

  typedef struct {
    logic [63:0] pc;
    logic        fl;
    logic        v;
    logic [63:0] upc;
    logic        tk;
    logic [63:0] tgt;
    logic        ptk;
    logic [63:0] ptgt;
    logic        e_pt;
    logic [63:0] e_ptg;
    logic        e_mp;
    logic [63:0] e_rd;
  } vec_t;

  vec_t tbl [19];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [63:0] tgts [4];
    tgts[0] = 64'h1000; tgts[1] = 64'h2000; tgts[2] = 64'h3000; tgts[3] = 64'hFFFF_FFFF_FFFF_FFFC;

    //             pc      fl    v     upc     tk    tgt     ptk   ptgt     e_pt  e_ptg   e_mp  e_rd
    tbl[0]  = '{64'h100, 1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   1'b0, 64'h0,   1'b0, 64'h104, 1'b0, 64'h4};
    tbl[1]  = '{64'h100, 1'b0, 1'b1, 64'h100, 1'b1, 64'h200, 1'b0, 64'h104, 1'b0, 64'h104, 1'b1, 64'h200};
    tbl[2]  = '{64'h100, 1'b0, 1'b1, 64'h100, 1'b1, 64'h200, 1'b1, 64'h200, 1'b1, 64'h200, 1'b0, 64'h200};
    tbl[3]  = '{64'h100, 1'b0, 1'b1, 64'h100, 1'b1, 64'h200, 1'b1, 64'h200, 1'b1, 64'h200, 1'b0, 64'h200};
    tbl[4]  = '{64'h100, 1'b0, 1'b1, 64'h100, 1'b0, 64'h200, 1'b1, 64'h200, 1'b1, 64'h200, 1'b1, 64'h104};
    tbl[5]  = '{64'h100, 1'b0, 1'b1, 64'h100, 1'b0, 64'h200, 1'b1, 64'h200, 1'b1, 64'h200, 1'b1, 64'h104};
    tbl[6]  = '{64'h100, 1'b0, 1'b1, 64'h100, 1'b0, 64'h200, 1'b0, 64'h104, 1'b0, 64'h104, 1'b0, 64'h104};
    tbl[7]  = '{64'h100, 1'b0, 1'b1, 64'h100, 1'b0, 64'h200, 1'b0, 64'h104, 1'b0, 64'h104, 1'b0, 64'h104};
    tbl[8]  = '{64'h100, 1'b0, 1'b1, 64'h100, 1'b1, 64'h200, 1'b0, 64'h104, 1'b0, 64'h104, 1'b1, 64'h200};
    tbl[9]  = '{64'h100, 1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   1'b0, 64'h0,   1'b0, 64'h104, 1'b0, 64'h4};
    tbl[10] = '{64'h100, 1'b0, 1'b1, 64'h100, 1'b1, 64'h200, 1'b0, 64'h104, 1'b0, 64'h104, 1'b1, 64'h200};
    tbl[11] = '{64'h100, 1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   1'b0, 64'h0,   1'b1, 64'h200, 1'b0, 64'h4};
    tbl[12] = '{64'h140, 1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   1'b0, 64'h0,   1'b0, 64'h144, 1'b0, 64'h4};
    tbl[13] = '{64'h140, 1'b0, 1'b1, 64'h140, 1'b1, 64'h500, 1'b0, 64'h144, 1'b0, 64'h144, 1'b1, 64'h500};
    tbl[14] = '{64'h100, 1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   1'b0, 64'h0,   1'b0, 64'h104, 1'b0, 64'h4};
    tbl[15] = '{64'h142, 1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   1'b0, 64'h0,   1'b1, 64'h500, 1'b0, 64'h4};
    tbl[16] = '{64'h140, 1'b1, 1'b1, 64'h300, 1'b1, 64'h700, 1'b0, 64'h304, 1'b1, 64'h500, 1'b1, 64'h700};
    tbl[17] = '{64'h300, 1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   1'b0, 64'h0,   1'b0, 64'h304, 1'b0, 64'h4};
    tbl[18] = '{64'h140, 1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   1'b0, 64'h0,   1'b0, 64'h144, 1'b0, 64'h4};

    reset = 1'b0;
    pc_F  = 64'h100;
    idle_inputs();
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.predTaken",  64'(predTaken_F), 64'd0);
    chk("rst.predTarget", predTarget_F,     64'h104);
    chk("rst.branchCnt",  64'(branchCnt),   64'd0);
    chk("rst.mispredCnt", 64'(mispredCnt),  64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) begin
      pc_F = tbl[i].pc; flush_all = tbl[i].fl; upd_valid = tbl[i].v; upd_pc = tbl[i].upc;
      upd_taken = tbl[i].tk; upd_target = tbl[i].tgt;
      upd_predTaken = tbl[i].ptk; upd_predTarget = tbl[i].ptgt;
      @(negedge clk);
      chk($sformatf("row%0d.predTaken", i),  64'(predTaken_F),  64'(tbl[i].e_pt));
      chk($sformatf("row%0d.predTarget", i), predTarget_F,      tbl[i].e_ptg);
      chk($sformatf("row%0d.mispredict", i), 64'(mispredict_M), 64'(tbl[i].e_mp));
      chk($sformatf("row%0d.redirect", i),   redirect_M,        tbl[i].e_rd);
      @(posedge clk);
      #1;
      m_update();
    end
    idle_inputs();
    @(negedge clk);
    chk("tbl.branchCnt",    64'(branchCnt),    64'd11);
    chk("tbl.mispredCnt",   64'(mispredCnt),   64'd7);
    chk("tbl.s_branchCnt",  64'(s_branchCnt),  64'd11);
    chk("tbl.s_mispredCnt", 64'(s_mispredCnt), 64'd7);
    @(posedge clk);
    #1;

    for (int c = 0; c < 1500; c++) begin
      pc_F       = rand_pc();
      upd_valid  = ($urandom_range(0, 3) != 0);
      upd_pc     = rand_pc();
      upd_taken  = 1'($urandom_range(0, 1));
      upd_target = tgts[$urandom_range(0, 3)];
      upd_predTaken  = ($urandom_range(0, 1) != 0) ? m_pred_taken(upd_pc) : 1'($urandom_range(0, 1));
      upd_predTarget = ($urandom_range(0, 1) != 0) ? m_pred_target(upd_pc) : tgts[$urandom_range(0, 3)];
      flush_all  = ($urandom_range(0, 63) == 0);
      step("rand");
    end

    // Build a known taken entry at 0x180, then drop reset in the middle of an update.
    idle_inputs();
    pc_F = 64'h180; upd_valid = 1'b1; upd_pc = 64'h180; upd_taken = 1'b1; upd_target = 64'h900;
    step("pre_rst0");
    step("pre_rst1");
    upd_valid = 1'b0;
    step("pre_rst2");
    upd_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("arst.predTaken",    64'(predTaken_F),  64'd0);
    chk("arst.predTarget",   predTarget_F,      64'h184);
    chk("arst.branchCnt",    64'(branchCnt),    64'd0);
    chk("arst.mispredCnt",   64'(mispredCnt),   64'd0);
    chk("arst.s_branchCnt",  64'(s_branchCnt),  64'd0);
    @(posedge clk);
    #1;
    chk("arst_hold.predTaken", 64'(predTaken_F), 64'd0);
    chk("arst_hold.branchCnt", 64'(branchCnt),   64'd0);
    #3;
    reset = 1'b1;
    m_reset();
    upd_valid = 1'b0;
    step("post_rst");

    for (int c = 0; c < 16; c++) begin
      pc_F = rand_pc(); upd_valid = 1'b1; upd_pc = rand_pc();
      upd_taken = 1'($urandom_range(0, 1)); upd_target = tgts[$urandom_range(0, 3)];
      upd_predTaken = 1'($urandom_range(0, 1)); upd_predTarget = tgts[$urandom_range(0, 3)];
      flush_all = 1'b0;
      step("sat");
    end
    idle_inputs();
    @(negedge clk);
    chk("sat.branchCnt",   64'(branchCnt),   64'd16);
    chk("sat.s_branchCnt", 64'(s_branchCnt), 64'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
